// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiplier / restoring divider with a one-cycle completion strobe.
// Fixed 33-cycle latency from start to strobe; divide-by-zero completes after one cycle.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] opd_q;
  logic [63:0] acc_q;
  logic        sign_q;
  logic        dz_q;
  logic [31:0] res_q;
  logic        exc_q;

  logic [31:0] abs_a, abs_b;
  logic [32:0] mult_sum;
  logic [63:0] mult_next;
  logic        div_qbit;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic        mult_exc;
  logic        div_exc;

  assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  // Multiply: acc holds {partial product, remaining multiplier bits}; add and shift right.
  assign mult_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opd_q : 32'd0)};
  assign mult_next = {mult_sum, acc_q[31:1]};

  // Divide: acc holds {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign div_qbit = (acc_q[63:31] >= {1'b0, opd_q});
  assign div_sub  = acc_q[62:31] - opd_q;
  assign div_next = {(div_qbit ? div_sub : acc_q[62:31]), acc_q[30:0], div_qbit};

  assign prod_fix = sign_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = sign_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign mult_exc = ~((&prod_fix[63:31]) | ~(|prod_fix[63:31]));
  // Only a quotient magnitude of 2^31 with a positive sign is unrepresentable.
  assign div_exc  = ~sign_q & acc_q[31];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      opd_q   <= 32'd0;
      acc_q   <= 64'd0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      cnt_q  <= 6'd0;
      sign_q <= data_operandA[31] ^ data_operandB[31];
      dz_q   <= (data_operandB == 32'd0);
      if (ctrl_MULT) begin
        state_q <= StMult;
        opd_q   <= abs_a;
        acc_q   <= {32'd0, abs_b};
      end else begin
        state_q <= StDiv;
        opd_q   <= abs_b;
        acc_q   <= {32'd0, abs_a};
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StMult: begin
          if (cnt_q != 6'd32) begin
            acc_q <= mult_next;
            cnt_q <= cnt_q + 6'd1;
          end else begin
            res_q   <= prod_fix[31:0];
            exc_q   <= mult_exc;
            state_q <= StDone;
          end
        end
        StDiv: begin
          if (dz_q) begin
            res_q   <= 32'd0;
            exc_q   <= 1'b1;
            state_q <= StDone;
          end else if (cnt_q != 6'd32) begin
            acc_q <= div_next;
            cnt_q <= cnt_q + 6'd1;
          end else begin
            res_q   <= quo_fix;
            exc_q   <= div_exc;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == StDone);
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and randomized checks of multdiv_unit against a plain-arithmetic signed reference.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int n_checks = 0;
  int n_fail = 0;

  localparam longint MaxInt = 64'sd2147483647;
  localparam longint MinInt = -64'sd2147483648;

  multdiv_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers, truncating division.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e, output int lat);
    longint sa, sb, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 33;
    if (is_mult) begin
      v = sa * sb;
      r = v[31:0];
      e = (v > MaxInt) || (v < MinInt);
    end else if (sb == 0) begin
      r = 32'd0;
      e = 1'b1;
      lat = 1;
    end else begin
      v = sa / sb;
      r = v[31:0];
      e = (v > MaxInt) || (v < MinInt);
    end
  endtask

  task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    // Operands are only sampled at the start edge.
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          rdy_edge;
    model(m, a, b, er, ee, lat);
    start(m, d, a, b);
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    rdy_edge = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        rdy_edge = k;
        break;
      end
    end
    check({tag, " latency"}, 32'(rdy_edge), 32'(lat));
    check({tag, " result"}, data_result, er);
    check({tag, " exception"}, 32'(data_exception), 32'(ee));
    check({tag, " busy_at_rdy"}, 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    check({tag, " rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    check({tag, " exc_held"}, 32'(data_exception), 32'(ee));
  endtask

  initial begin
    int          first_rdy;
    int          rdy_count;
    logic [31:0] prev_res;
    logic [31:0] ra, rb;
    bit          rm;

    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #12;
    check("reset result", data_result, 32'd0);
    check("reset exception", 32'(data_exception), 32'd0);
    check("reset rdy", 32'(data_resultRDY), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(1, 0, 32'd7, 32'hFFFF_FFFA, "mul_small");
    run_op(1, 0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    run_op(1, 0, 32'h8000_0000, 32'd1, "mul_minint");
    run_op(0, 1, 32'd100, 32'hFFFF_FFF9, "div_neg");
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(0, 1, 32'd5, 32'd0, "div_zero");
    run_op(1, 1, 32'd3, 32'd4, "both_start");

    // Restart: a divide at edge 10 aborts the multiply; only the divide completes.
    prev_res = data_result;
    start(1, 0, 32'd3, 32'd4);
    check("restart result_held", data_result, prev_res);
    first_rdy = -1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY && first_rdy < 0) first_rdy = k;
    end
    start(0, 1, 32'd20, 32'd4);
    for (int k = 11; k <= 50; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY && first_rdy < 0) first_rdy = k;
    end
    check("restart rdy_edge", 32'(first_rdy), 32'd43);
    check("restart result", data_result, 32'd5);
    check("restart exception", 32'(data_exception), 32'd0);

    // Back-to-back: new start sampled on the edge that leaves DONE.
    start(1, 0, 32'd5, 32'd6);
    first_rdy = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        first_rdy = k;
        break;
      end
    end
    check("b2b first rdy", 32'(first_rdy), 32'd33);
    check("b2b first result", data_result, 32'd30);
    start(0, 1, 32'd42, 32'd5);
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b rdy_dropped", 32'(data_resultRDY), 32'd0);
    first_rdy = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        first_rdy = k;
        break;
      end
    end
    check("b2b second rdy", 32'(first_rdy), 32'd33);
    check("b2b second result", data_result, 32'd8);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: ra = 32'($urandom_range(0, 300));
        1: ra = -32'($urandom_range(0, 300));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 15));
        1: rb = -32'($urandom_range(1, 15));
        2: rb = 32'($urandom_range(0, 70000));
        default: rb = $urandom;
      endcase
      run_op(rm, ~rm, ra, rb, $sformatf("rand%0d_%s_%h_%h", i, rm ? "mul" : "div", ra, rb));
    end

    // Reset in the middle of a multiply clears everything and suppresses the strobe.
    start(1, 0, 32'd9, 32'd9);
    repeat (15) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset result", data_result, 32'd0);
    check("midreset exception", 32'(data_exception), 32'd0);
    check("midreset rdy", 32'(data_resultRDY), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_count = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_count++;
    end
    check("midreset no_rdy", 32'(rdy_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
